// File: rtl/cpu_mem_arbiter_if.sv
// Shared memory bus between OAM DMA, execute and fetch requesters.
// The arbiter takes the slave view; requesters and memory take the master view.
interface cpu_mem_arbiter_if;
  logic        dma_req;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic        dma_rw_n;
  logic        dma_gnt;
  logic        dma_rvalid;
  logic        ex_req;
  logic [15:0] ex_addr;
  logic [7:0]  ex_wdata;
  logic        ex_rw_n;
  logic        ex_gnt;
  logic        ex_rvalid;
  logic        fe_req;
  logic [15:0] fe_addr;
  logic [7:0]  fe_wdata;
  logic        fe_rw_n;
  logic        fe_gnt;
  logic        fe_rvalid;
  logic [7:0]  rdata;
  logic        mem_en;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_rw_n;
  logic [7:0]  mem_rdata;
  logic        cpu_halt;

  modport slave (
    input  dma_req, dma_addr, dma_wdata, dma_rw_n,
    input  ex_req, ex_addr, ex_wdata, ex_rw_n,
    input  fe_req, fe_addr, fe_wdata, fe_rw_n,
    input  mem_rdata,
    output dma_gnt, dma_rvalid, ex_gnt, ex_rvalid,
    output fe_gnt, fe_rvalid, rdata, cpu_halt,
    output mem_en, mem_addr, mem_wdata, mem_rw_n
  );

  modport master (
    output dma_req, dma_addr, dma_wdata, dma_rw_n,
    output ex_req, ex_addr, ex_wdata, ex_rw_n,
    output fe_req, fe_addr, fe_wdata, fe_rw_n,
    output mem_rdata,
    input  dma_gnt, dma_rvalid, ex_gnt, ex_rvalid,
    input  fe_gnt, fe_rvalid, rdata, cpu_halt,
    input  mem_en, mem_addr, mem_wdata, mem_rw_n
  );
endinterface

// File: rtl/cpu_mem_arbiter.sv
// Single-port memory arbiter for the NES CPU: DMA > execute > fetch,
// registered grants, burst limiting, tagged read return and cpu_halt.
module cpu_mem_arbiter #(
  parameter int unsigned MAX_BURST = 4,
  parameter bit          DMA_LOCK  = 1'b1
) (
  input logic             clk,
  input logic             rst_n,
  cpu_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_DMA,
    OWN_EX,
    OWN_FE
  } own_t;

  localparam logic [3:0] MB = 4'(MAX_BURST);

  own_t        own_q, own_d;
  own_t        pend_id;
  logic        pend_v;
  logic [3:0]  cnt_q, cnt_d, cnt_inc;
  logic [2:0]  req, own_oh, others, rv_q;
  logic        beat, limited;
  logic [15:0] sel_addr, addr_q;
  logic [7:0]  sel_wdata, wdata_q, rdata_q;
  logic        sel_rw_n, rw_n_q, en_q;

  function automatic own_t pick(input logic [2:0] r);
    if (r[0])      return OWN_DMA;
    else if (r[1]) return OWN_EX;
    else if (r[2]) return OWN_FE;
    else           return OWN_NONE;
  endfunction

  assign req     = {bus.fe_req, bus.ex_req, bus.dma_req};
  assign own_oh  = {own_q == OWN_FE, own_q == OWN_EX,
                    own_q == OWN_DMA};
  assign others  = req & ~own_oh;
  assign beat    = |(req & own_oh);
  assign cnt_inc = (cnt_q == 4'hf) ? 4'hf : cnt_q + 4'd1;
  assign limited = (own_q == OWN_EX) || (own_q == OWN_FE) ||
                   ((own_q == OWN_DMA) && !DMA_LOCK);

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_rw_n  = 1'b1;
    unique case (own_q)
      OWN_DMA: begin
        sel_addr  = bus.dma_addr;
        sel_wdata = bus.dma_wdata;
        sel_rw_n  = bus.dma_rw_n;
      end
      OWN_EX: begin
        sel_addr  = bus.ex_addr;
        sel_wdata = bus.ex_wdata;
        sel_rw_n  = bus.ex_rw_n;
      end
      OWN_FE: begin
        sel_addr  = bus.fe_addr;
        sel_wdata = bus.fe_wdata;
        sel_rw_n  = bus.fe_rw_n;
      end
      default: ;
    endcase
  end

  // DMA preempts fetch only; everything else waits for release or burst limit
  always_comb begin
    own_d = own_q;
    if (own_q == OWN_NONE)
      own_d = pick(req);
    else if (!beat)
      own_d = pick(others);
    else if ((own_q == OWN_FE) && req[0])
      own_d = OWN_DMA;
    else if (limited && (cnt_inc >= MB) && |others)
      own_d = pick(others);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (own_d != own_q) cnt_d = '0;
    else if (beat)      cnt_d = cnt_inc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      own_q   <= OWN_NONE;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rw_n_q  <= 1'b1;
      pend_v  <= 1'b0;
      pend_id <= OWN_NONE;
      rv_q    <= '0;
      rdata_q <= '0;
    end else begin
      own_q   <= own_d;
      cnt_q   <= cnt_d;
      en_q    <= beat;
      if (beat) begin
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
        rw_n_q  <= sel_rw_n;
      end
      pend_v  <= beat && sel_rw_n;
      pend_id <= own_q;
      rv_q    <= {pend_v && (pend_id == OWN_FE),
                  pend_v && (pend_id == OWN_EX),
                  pend_v && (pend_id == OWN_DMA)};
      if (pend_v) rdata_q <= bus.mem_rdata;
    end
  end

  assign bus.dma_gnt    = (own_q == OWN_DMA);
  assign bus.ex_gnt     = (own_q == OWN_EX);
  assign bus.fe_gnt     = (own_q == OWN_FE);
  assign bus.cpu_halt   = (own_q == OWN_DMA);
  assign bus.dma_rvalid = rv_q[0];
  assign bus.ex_rvalid  = rv_q[1];
  assign bus.fe_rvalid  = rv_q[2];
  assign bus.rdata      = rdata_q;
  assign bus.mem_en     = en_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.mem_rw_n   = rw_n_q;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Bench for cpu_mem_arbiter: directed steps plus random traffic,
// every output compared each cycle against a transaction-level model.
module tb_cpu_mem_arbiter;

  localparam int MB   = 4;
  localparam bit LOCK = 1'b1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cpu_mem_arbiter_if bus();

  cpu_mem_arbiter #(.MAX_BURST(MB), .DMA_LOCK(LOCK)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    int id;
    int cyc;
  } rd_t;

  int checks = 0;
  int errors = 0;

  logic        r_req[3];
  logic [15:0] r_addr[3];
  logic [7:0]  r_wd[3];
  logic        r_rw[3];
  logic [7:0]  r_mrd;

  int          m_own;
  int          m_beats;
  int          cyc;
  bit          m_beat[3];
  rd_t         pend[$];
  bit          e_gnt[3];
  bit          e_rv[3];
  bit          e_en;
  bit          e_rw;
  logic [15:0] e_addr;
  logic [7:0]  e_wd;
  logic [7:0]  e_rdata;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    bus.dma_req   = r_req[0];
    bus.dma_addr  = r_addr[0];
    bus.dma_wdata = r_wd[0];
    bus.dma_rw_n  = r_rw[0];
    bus.ex_req    = r_req[1];
    bus.ex_addr   = r_addr[1];
    bus.ex_wdata  = r_wd[1];
    bus.ex_rw_n   = r_rw[1];
    bus.fe_req    = r_req[2];
    bus.fe_addr   = r_addr[2];
    bus.fe_wdata  = r_wd[2];
    bus.fe_rw_n   = r_rw[2];
    bus.mem_rdata = r_mrd;
  endtask

  function automatic int winner(input int excl);
    for (int i = 0; i < 3; i++)
      if (r_req[i] && i != excl) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_own   = -1;
    m_beats = 0;
    pend.delete();
    for (int i = 0; i < 3; i++) begin
      e_gnt[i]  = 1'b0;
      e_rv[i]   = 1'b0;
      m_beat[i] = 1'b0;
    end
    e_en    = 1'b0;
    e_rw    = 1'b1;
    e_addr  = '0;
    e_wd    = '0;
    e_rdata = '0;
  endtask

  // Advance the model across one clock edge using the current inputs
  task automatic model_step();
    int  nxt;
    int  b;
    bit  beat;
    rd_t r;
    for (int i = 0; i < 3; i++) begin
      e_rv[i]   = 1'b0;
      m_beat[i] = 1'b0;
    end
    if (pend.size() > 0 && pend[0].cyc == cyc - 1) begin
      e_rv[pend[0].id] = 1'b1;
      e_rdata = r_mrd;
      pend.delete(0);
    end
    beat = (m_own >= 0) && r_req[m_own];
    e_en = beat;
    if (beat) begin
      m_beat[m_own] = 1'b1;
      e_addr = r_addr[m_own];
      e_wd   = r_wd[m_own];
      e_rw   = r_rw[m_own];
      if (r_rw[m_own]) begin
        r.id  = m_own;
        r.cyc = cyc;
        pend.push_back(r);
      end
    end
    b   = (m_beats < 15) ? m_beats + 1 : 15;
    nxt = m_own;
    if (m_own < 0)
      nxt = winner(-1);
    else if (!r_req[m_own])
      nxt = winner(m_own);
    else if (m_own == 2 && r_req[0])
      nxt = 0;
    else if ((m_own != 0 || !LOCK) && b >= MB && winner(m_own) >= 0)
      nxt = winner(m_own);
    if (nxt != m_own) m_beats = 0;
    else if (beat)    m_beats = b;
    m_own = nxt;
    for (int i = 0; i < 3; i++) e_gnt[i] = (m_own == i);
    cyc++;
  endtask

  task automatic check();
    chk("dma_gnt",    16'(bus.dma_gnt),    16'(e_gnt[0]));
    chk("ex_gnt",     16'(bus.ex_gnt),     16'(e_gnt[1]));
    chk("fe_gnt",     16'(bus.fe_gnt),     16'(e_gnt[2]));
    chk("cpu_halt",   16'(bus.cpu_halt),   16'(e_gnt[0]));
    chk("dma_rvalid", 16'(bus.dma_rvalid), 16'(e_rv[0]));
    chk("ex_rvalid",  16'(bus.ex_rvalid),  16'(e_rv[1]));
    chk("fe_rvalid",  16'(bus.fe_rvalid),  16'(e_rv[2]));
    chk("rdata",      16'(bus.rdata),      16'(e_rdata));
    chk("mem_en",     16'(bus.mem_en),     16'(e_en));
    chk("mem_addr",   bus.mem_addr,        e_addr);
    chk("mem_wdata",  16'(bus.mem_wdata),  16'(e_wd));
    chk("mem_rw_n",   16'(bus.mem_rw_n),   16'(e_rw));
  endtask

  task automatic tick();
    drive();
    model_step();
    @(posedge clk);
    #1;
    check();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < 3; i++) r_req[i] = 1'b0;
    for (int k = 0; k < n; k++) tick();
  endtask

  // A requester may change its request only once served or idle
  task automatic rand_inputs(input int pdma);
    for (int i = 0; i < 3; i++) begin
      if (!r_req[i] || m_beat[i]) begin
        if (i == 0 && r_req[0])
          r_req[0] = ($urandom_range(99) < 85);
        else if (i == 0)
          r_req[0] = ($urandom_range(99) < pdma);
        else if (!(r_req[i] && e_gnt[0]))
          r_req[i] = ($urandom_range(99) < 60);
        r_addr[i] = 16'($urandom);
        r_wd[i]   = 8'($urandom);
        r_rw[i]   = ($urandom_range(3) != 0);
      end
    end
    r_mrd = 8'($urandom);
  endtask

  initial begin
    int dcount;
    int guard;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      r_req[i]  = 1'b0;
      r_addr[i] = '0;
      r_wd[i]   = '0;
      r_rw[i]   = 1'b1;
    end
    r_mrd = '0;
    drive();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    cyc = 0;
    check();
    @(posedge clk);
    #2 rst_n = 1'b1;

    // single execute read
    r_req[1] = 1'b1; r_addr[1] = 16'h0024; r_rw[1] = 1'b1;
    tick();
    tick();
    r_req[1] = 1'b0; r_mrd = 8'h5a;
    tick();
    tick();
    chk("ex_read_data", 16'(bus.rdata), 16'h005a);
    idle(2);

    // execute write produces no rvalid
    r_req[1] = 1'b1; r_addr[1] = 16'h2004;
    r_wd[1] = 8'hc3; r_rw[1] = 1'b0;
    tick();
    tick();
    r_req[1] = 1'b0;
    tick();
    chk("ex_wr_data", 16'(bus.mem_wdata), 16'h00c3);
    idle(3);

    // simultaneous EX/FE, then drop EX for zero-cycle handover
    r_req[1] = 1'b1; r_addr[1] = 16'h0100; r_rw[1] = 1'b1;
    r_req[2] = 1'b1; r_addr[2] = 16'h8000; r_rw[2] = 1'b1;
    tick();
    tick();
    r_req[1] = 1'b0;
    tick();
    chk("fe_handover", 16'(bus.fe_gnt), 16'h0001);

    // both held: alternating bursts of MAX_BURST
    r_req[1] = 1'b1;
    for (int k = 0; k < 24; k++) begin
      r_mrd = 8'($urandom);
      tick();
    end
    idle(4);

    // fetch bursting, DMA preempts and runs 256 locked beats
    r_req[2] = 1'b1; r_addr[2] = 16'hc000; r_rw[2] = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    r_req[0] = 1'b1; r_addr[0] = 16'h0200; r_rw[0] = 1'b1;
    r_req[1] = 1'b1; r_addr[1] = 16'h0300; r_rw[1] = 1'b1;
    dcount = 0;
    guard  = 0;
    while (dcount < 256 && guard < 600) begin
      r_mrd = 8'($urandom);
      tick();
      guard++;
      if (m_beat[0]) dcount++;
      if (dcount >= 256) r_req[0] = 1'b0;
      else r_addr[0] = 16'h0200 + 16'(dcount);
    end
    chk("dma_beats", 16'(dcount), 16'd256);
    for (int k = 0; k < 6; k++) tick();
    idle(4);

    // reset with a read outstanding
    r_req[1] = 1'b1; r_addr[1] = 16'h1234; r_rw[1] = 1'b1;
    tick();
    tick();
    r_req[1] = 1'b0;
    drive();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check();
    @(posedge clk);
    #1;
    check();
    #2 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    r_req[2] = 1'b1; r_addr[2] = 16'h4444; r_rw[2] = 1'b1;
    tick();
    chk("restart_fe_gnt", 16'(bus.fe_gnt), 16'h0001);
    idle(3);

    // random traffic
    for (int k = 0; k < 800; k++) begin
      rand_inputs(8);
      tick();
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_mem_arbiter.md
Name: cpu_mem_arbiter

Overview:
Single-port memory bus arbiter for the NES CPU core. It shares one synchronous memory port between three requesters: OAM DMA, the execute stage (operand and indirect-pointer accesses) and the fetch stage (opcode and operand bytes). Grants are registered and priority-based with burst limiting. It returns read data to the owning requester and raises cpu_halt while DMA owns the bus, so the pipeline stalls.

Parameters:
MAX_BURST, 4, maximum consecutive beats a CPU requester (execute/fetch) may hold the bus while another requester waits; range 1..15.
DMA_LOCK, 1, 1: DMA is never preempted and bursts until its req drops; 0: DMA is also limited by MAX_BURST.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
dma_req  in  1  DMA access request (priority 0, highest)
dma_addr  in  16  DMA address
dma_wdata  in  8  DMA write data
dma_rw_n  in  1  1 = read, 0 = write
dma_gnt  out  1  DMA owns bus
dma_rvalid  out  1  read data for DMA valid on rdata
ex_req / ex_addr / ex_wdata / ex_rw_n  in  1/16/8/1  execute-stage request (priority 1)
ex_gnt / ex_rvalid  out  1/1  execute-stage grant / read-valid
fe_req / fe_addr / fe_wdata / fe_rw_n  in  1/16/8/1  fetch-stage request (priority 2, lowest)
fe_gnt / fe_rvalid  out  1/1  fetch-stage grant / read-valid
rdata  out  8  registered read data, shared by all requesters
mem_en  out  1  memory access strobe
mem_addr  out  16  memory address
mem_wdata  out  8  memory write data
mem_rw_n  out  1  memory direction
mem_rdata  in  8  memory read data, valid the cycle after mem_en with mem_rw_n=1
cpu_halt  out  1  high while dma_gnt is high

Behaviour:
- Reset (asynchronous, any time, including mid-burst or with a read outstanding):
  - All gnt, rvalid, mem_en and cpu_halt go to 0.
  - mem_addr=0, mem_wdata=0, rdata=0, mem_rw_n=1.
  - Beat counter = 0; owner = NONE; outstanding read discarded, with no rvalid after reset release.
- State: owner ∈ {NONE, DMA, EX, FE}. At most one gnt is high, and gnt = (owner == that requester), registered.
- Beat:
  - A beat occurs in cycle N when a requester's gnt=1 and req=1.
  - On the edge ending cycle N, mem_en=1 and mem_addr/mem_wdata/mem_rw_n are registered from that requester's inputs, so they are valid in cycle N+1.
  - With no beat, mem_en=0 next cycle and other mem_* outputs hold their values.
- Read return:
  - For a read beat in N, mem_rdata is sampled at the end of N+1.
  - rdata and the issuing requester's rvalid are high in cycle N+2 for exactly one cycle.
  - This is tagged to the issuer even if ownership changed since.
  - Back-to-back reads give rvalid on consecutive cycles.
  - Write beats never produce rvalid.
- Beat counter: 4 bits. Cleared on ownership change; incremented per beat, saturating at 15.
- Arbitration, evaluated every edge:
  - owner NONE: the highest-priority asserted req wins and its gnt rises next cycle. The first beat is the cycle after req, so there is 1-cycle grant latency.
  - Owner's req low: release. The new winner among the other reqs is granted at the same edge (zero-cycle handover); otherwise owner becomes NONE.
  - Owner EX/FE (or DMA with DMA_LOCK=0): if beat count reaches MAX_BURST on this beat and any other req is high, hand over to the highest-priority other requester. The current owner keeps its req pending and re-competes normally.
  - A higher-priority req arriving mid-burst does not preempt. It waits for release or the burst limit, except DMA, which preempts FE (not EX) at the next edge after the current beat.
  - Simultaneous requests resolve DMA > EX > FE.
- cpu_halt = dma_gnt (registered, same timing). The execute and fetch stages must hold their requests while halted.
- Requesters must keep addr/wdata/rw_n stable while req=1 and gnt=0. Dropping req without ever being granted is legal.

Test Plan:
- Reset, then ex_req=1, ex_addr=0x0024, read → ex_gnt high next cycle; mem_en=1, mem_addr=0x0024 the cycle after; mem_rdata=0x5A gives ex_rvalid=1, rdata=0x5A two cycles after the beat.
- fe_req and ex_req asserted in the same cycle → ex_gnt first; FE granted at the edge where ex_req drops, with no idle cycle between.
- EX and FE held high continuously, MAX_BURST=4 → exactly 4 EX beats, then 4 FE beats, alternating; the rvalid pattern matches the issuing requester.
- FE bursting, then dma_req=1 with 256 reads at 0x0200–0x02FF → FE preempted after its current beat; dma_gnt=cpu_halt=1 for all 256 beats (DMA_LOCK=1); ex_req ignored until dma_req drops.
- Write beat from EX (addr 0x2004, data 0xC3) → mem_rw_n=0, mem_wdata=0xC3 for one cycle; no ex_rvalid.
- rst_n pulsed low one cycle after a read beat → all outputs at reset values asynchronously; no rvalid after release; arbitration restarts from NONE.
